// File: rtl/note_playback_sched_if.sv
// Bundle of request, note-ROM and Audio_Controller signals for note_playback_sched.
// NOTE_PLAYBACK_VOLUME_EN adds the 3-bit volume input.
interface note_playback_sched_if #(
    parameter int NUM_NOTES = 4,
    parameter int ADDR_W    = 16,
    parameter int SAMPLE_W  = 10
);
    logic [NUM_NOTES-1:0] note_req;
    logic [SAMPLE_W-1:0]  rom_q;
    logic                 audio_out_allowed;
    logic [ADDR_W-1:0]    rom_addr;
    logic [2:0]           note_sel;
    logic [31:0]          sample_out;
    logic                 write_audio_out;
    logic                 busy;
`ifdef NOTE_PLAYBACK_VOLUME_EN
    logic [2:0]           volume;

    // Scheduler side: owns the ROM address bus and the DAC write strobe.
    modport master (
        input  note_req, rom_q, audio_out_allowed, volume,
        output rom_addr, note_sel, sample_out, write_audio_out, busy
    );

    modport slave (
        output note_req, rom_q, audio_out_allowed, volume,
        input  rom_addr, note_sel, sample_out, write_audio_out, busy
    );
`else
    // Scheduler side: owns the ROM address bus and the DAC write strobe.
    modport master (
        input  note_req, rom_q, audio_out_allowed,
        output rom_addr, note_sel, sample_out, write_audio_out, busy
    );

    modport slave (
        output note_req, rom_q, audio_out_allowed,
        input  rom_addr, note_sel, sample_out, write_audio_out, busy
    );
`endif
endinterface

// File: rtl/note_playback_sched.sv
// Fixed-priority note playback scheduler: one ROM fetch and one DAC write per sample.
// Optional NOTE_PLAYBACK_VOLUME_EN: arithmetic right shift of each sample by bus.volume.
module note_playback_sched #(
    parameter int NUM_NOTES = 4,
    parameter int ADDR_W    = 16,
    parameter int LAST_ADDR = 16383,
    parameter int SAMPLE_W  = 10,
    parameter int ROM_LAT   = 1
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    note_playback_sched_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [1:0]        LAT_LAST = 2'(ROM_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(LAST_ADDR);

    state_t               state_q, state_d;
    logic [1:0]           lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
    logic [2:0]           note_sel_q, note_sel_d;
    logic [31:0]          sample_out_q, sample_out_d;
    logic                 write_audio_out_q, write_audio_out_d;
    logic                 busy_q, busy_d;
    logic [2:0]           winner;
    logic [ADDR_W-1:0]    addr_next;

    // Lowest set index wins; an all-zero request returns 0 and is gated by the caller.
    function automatic logic [2:0] pick_winner(input logic [NUM_NOTES-1:0] req);
        logic [2:0] w;
        w = '0;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (req[i]) w = 3'(i);
        end
        return w;
    endfunction

    // Offset-binary ROM word -> left-justified two's complement (flip the MSB).
`ifdef NOTE_PLAYBACK_VOLUME_EN
    function automatic logic signed [31:0] format_sample(input logic [SAMPLE_W-1:0] q,
                                                         input logic [2:0]          vol);
        logic signed [31:0] s;
        s = {~q[SAMPLE_W-1], q[SAMPLE_W-2:0], {(32 - SAMPLE_W){1'b0}}};
        return s >>> vol;
    endfunction
`else
    function automatic logic signed [31:0] format_sample(input logic [SAMPLE_W-1:0] q);
        logic signed [31:0] s;
        s = {~q[SAMPLE_W-1], q[SAMPLE_W-2:0], {(32 - SAMPLE_W){1'b0}}};
        return s;
    endfunction
`endif

    assign winner    = pick_winner(bus.note_req);
    assign addr_next = (rom_addr_q == ADDR_END) ? '0 : rom_addr_q + ADDR_W'(1);

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        rom_addr_d   = rom_addr_q;
        note_sel_d   = note_sel_q;
        sample_out_d = sample_out_q;

        unique case (state_q)
            IDLE: begin
                if (|bus.note_req) begin
                    note_sel_d = winner;
                    rom_addr_d = '0;
                    lat_cnt_d  = '0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                lat_cnt_d = lat_cnt_q + 2'd1;
                if (lat_cnt_q == LAT_LAST) begin
`ifdef NOTE_PLAYBACK_VOLUME_EN
                    sample_out_d = format_sample(bus.rom_q, bus.volume);
`else
                    sample_out_d = format_sample(bus.rom_q);
`endif
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.audio_out_allowed) state_d = WRITE;
            end
            WRITE: begin
                // Re-arbitration point: the only place a playing note can change.
                lat_cnt_d = '0;
                if (!(|bus.note_req)) begin
                    rom_addr_d = '0;
                    state_d    = IDLE;
                end else if (winner == note_sel_q) begin
                    rom_addr_d = addr_next;
                    state_d    = FETCH;
                end else begin
                    note_sel_d = winner;
                    rom_addr_d = '0;
                    state_d    = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobe and busy are registered from the next state so they align with it.
        write_audio_out_d = (state_d == WRITE);
        busy_d            = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q           <= IDLE;
            lat_cnt_q         <= '0;
            rom_addr_q        <= '0;
            note_sel_q        <= '0;
            sample_out_q      <= '0;
            write_audio_out_q <= 1'b0;
            busy_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            lat_cnt_q         <= lat_cnt_d;
            rom_addr_q        <= rom_addr_d;
            note_sel_q        <= note_sel_d;
            sample_out_q      <= sample_out_d;
            write_audio_out_q <= write_audio_out_d;
            busy_q            <= busy_d;
        end
    end

    assign bus.rom_addr        = rom_addr_q;
    assign bus.note_sel        = note_sel_q;
    assign bus.sample_out      = sample_out_q;
    assign bus.write_audio_out = write_audio_out_q;
    assign bus.busy            = busy_q;

endmodule

// File: tb/tb_note_playback_sched.sv
// Scoreboard bench for note_playback_sched: stimulus queues expected writes, a monitor checks them.
module tb_note_playback_sched;

    localparam int NUM_NOTES = 4;
    localparam int ADDR_W    = 16;
    localparam int LAST_ADDR = 16383;
    localparam int SAMPLE_W  = 10;
    localparam int ROM_LAT   = 1;

    typedef struct {
        logic [2:0]        sel;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       smp;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_cnt  = 0;
    int   last_wr  = -1;
    bit   gap_chk  = 1'b0;
    bit   rom_fixed_en;
    logic [SAMPLE_W-1:0] rom_fixed;
    exp_t sb[$];

    note_playback_sched_if #(.NUM_NOTES(NUM_NOTES), .ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) bus ();

    note_playback_sched #(
        .NUM_NOTES(NUM_NOTES), .ADDR_W(ADDR_W), .LAST_ADDR(LAST_ADDR),
        .SAMPLE_W(SAMPLE_W), .ROM_LAT(ROM_LAT)
    ) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // ROM model: either a constant word or a word encoding the note and low address bits.
    assign bus.rom_q = rom_fixed_en ? rom_fixed : {bus.note_sel, bus.rom_addr[6:0]};

    function automatic logic [31:0] coded_sample(input logic [2:0] sel, input int addr);
        logic [9:0] q;
        q = {sel, 7'(addr)};
        return {~q[9], q[8:0], 22'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] sel, input int addr, input logic [31:0] smp);
        exp_t e;
        e.sel  = sel;
        e.addr = ADDR_W'(addr);
        e.smp  = smp;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Advance until n further writes are seen, bounded by a cycle budget.
    task automatic wait_writes(input int n, input int budget);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.write_audio_out) begin
                seen++;
                if (gap_chk && last_wr >= 0) chk("write_gap", 32'(cyc_cnt - last_wr), 32'd3);
                last_wr = cyc_cnt;
            end
        end
        if (seen < n) chk("write_timeout", 32'(seen), 32'(n));
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.write_audio_out) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_note_sel", 32'(bus.note_sel), 32'(e.sel));
                chk("wr_rom_addr", 32'(bus.rom_addr), 32'(e.addr));
                chk("wr_sample", bus.sample_out, e.smp);
            end
        end
    end

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn            = 1'b0;
        bus.note_req      = '0;
        bus.audio_out_allowed = 1'b1;
`ifdef NOTE_PLAYBACK_VOLUME_EN
        bus.volume        = 3'd0;
`endif
        rom_fixed_en      = 1'b1;
        rom_fixed         = 10'h200;
        tick();
        tick();
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_note_sel", 32'(bus.note_sel), 32'd0);
        chk("rst_sample", bus.sample_out, 32'd0);
        chk("rst_write", 32'(bus.write_audio_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        resetn = 1'b1;
        tick();

        // Single note 2, mid-scale word: first write on cycle 3, addresses 0,1,2, release mid-FETCH.
        push_exp(3'd2, 0, 32'h0000_0000);
        push_exp(3'd2, 1, 32'h0000_0000);
        push_exp(3'd2, 2, 32'h0000_0000);
        bus.note_req = 4'b0100;
        tick();
        chk("lat_c1_write", 32'(bus.write_audio_out), 32'd0);
        chk("lat_c1_busy", 32'(bus.busy), 32'd1);
        chk("lat_note_sel", 32'(bus.note_sel), 32'd2);
        tick();
        chk("lat_c2_write", 32'(bus.write_audio_out), 32'd0);
        tick();
        chk("lat_c3_write", 32'(bus.write_audio_out), 32'd1);
        wait_writes(1, 10);
        tick();
        bus.note_req = 4'b0000;
        wait_writes(1, 10);
        tick();
        chk("rel_busy", 32'(bus.busy), 32'd0);
        chk("rel_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("rel_write", 32'(bus.write_audio_out), 32'd0);

        // Note 2 to address 37, then note 0 arrives and preempts at the write boundary.
        rom_fixed_en = 1'b0;
        for (int a = 0; a <= 37; a++) push_exp(3'd2, a, coded_sample(3'd2, a));
        push_exp(3'd0, 0, 32'h8000_0000);
        push_exp(3'd0, 1, 32'h8040_0000);
        bus.note_req = 4'b0100;
        wait_writes(37, 37 * 3 + 10);
        tick();
        bus.note_req = 4'b0101;
        wait_writes(2, 20);
        tick();
        bus.note_req = 4'b0000;
        wait_writes(1, 10);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_hold_sample", bus.sample_out, 32'h8040_0000);
        end
        chk("sw_busy", 32'(bus.busy), 32'd0);
        chk("sw_note_sel", 32'(bus.note_sel), 32'd0);

        // Full sweep of note 1 across the wrap: 0..LAST_ADDR then 0, no gap cycle.
        for (int a = 0; a <= LAST_ADDR; a++) push_exp(3'd1, a, coded_sample(3'd1, a));
        push_exp(3'd1, 0, coded_sample(3'd1, 0));
        gap_chk = 1'b1;
        last_wr = -1;
        bus.note_req = 4'b0010;
        wait_writes(LAST_ADDR + 1, (LAST_ADDR + 1) * 3 + 20);
        tick();
        bus.note_req = 4'b0000;
        wait_writes(1, 10);
        gap_chk = 1'b0;
        tick();
        chk("wrap_busy", 32'(bus.busy), 32'd0);
        chk("wrap_rom_addr", 32'(bus.rom_addr), 32'd0);

        // Backpressure: 50 cycles in HOLD, then exactly one write.
        rom_fixed_en = 1'b1;
        rom_fixed    = 10'h155;
        bus.audio_out_allowed = 1'b0;
        push_exp(3'd1, 0, 32'hD540_0000);
        bus.note_req = 4'b0010;
        tick();
        tick();
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("bp_write", 32'(bus.write_audio_out), 32'd0);
            chk("bp_sample", bus.sample_out, 32'hD540_0000);
            chk("bp_busy", 32'(bus.busy), 32'd1);
            chk("bp_rom_addr", 32'(bus.rom_addr), 32'd0);
        end
        bus.audio_out_allowed = 1'b1;
        tick();
        chk("bp_release_write", 32'(bus.write_audio_out), 32'd1);
        bus.note_req = 4'b0000;
        tick();
        chk("bp_single_write", 32'(bus.write_audio_out), 32'd0);
        chk("bp_idle", 32'(bus.busy), 32'd0);

        // Asynchronous reset while waiting in HOLD: outputs clear at once, no write.
        bus.audio_out_allowed = 1'b0;
        bus.note_req = 4'b0100;
        tick();
        tick();
        chk("pre_rst_sample", bus.sample_out, 32'hD540_0000);
        resetn = 1'b0;
        #1;
        chk("arst_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("arst_note_sel", 32'(bus.note_sel), 32'd0);
        chk("arst_sample", bus.sample_out, 32'd0);
        chk("arst_write", 32'(bus.write_audio_out), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        bus.note_req = 4'b0000;
        bus.audio_out_allowed = 1'b1;
        tick();
        resetn = 1'b1;
        tick();
        tick();
        chk("post_rst_write", 32'(bus.write_audio_out), 32'd0);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

`ifdef NOTE_PLAYBACK_VOLUME_EN
        // Volume 3 on full-scale word 3FF: 7FC0_0000 >>> 3.
        bus.volume = 3'd3;
        rom_fixed  = 10'h3FF;
        push_exp(3'd0, 0, 32'h0FF8_0000);
        bus.note_req = 4'b0001;
        wait_writes(1, 10);
        bus.note_req = 4'b0000;
        tick();
        chk("vol_sample_hold", bus.sample_out, 32'h0FF8_0000);
        chk("vol_busy", 32'(bus.busy), 32'd0);
`endif

        tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
